// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared state encoding and sizing constants for rom_loader
package rom_loader_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bytes per ROM word; addresses advance in steps of this size
  localparam int unsigned WORD_BYTES = 4;

  // Default ROM size in bytes (must be a multiple of WORD_BYTES)
  localparam logic [31:0] DEFAULT_ROM_BYTES = 32'h8000;

  // True when the state drives the busy flag
  function automatic logic is_busy_state(input state_e s);
    return (s == ST_WRITE) || (s == ST_READ) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/rom_loader_skid.sv
// rtl/rom_loader_skid.sv - one-entry skid register for the readback return path
module rom_loader_skid (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;

  // Next-state: flush wins, then capture, then release
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - ROM programming/readback controller; optional checksum via ROM_LOADER_CHECKSUM_EN
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [31:0] ROM_BYTES = DEFAULT_ROM_BYTES,
  parameter int          ADDR_W    = 32
) (
  input  logic              core_clk_i,
  input  logic              reset_i,
  input  logic              program_en_i,
  input  logic              start_i,
  input  logic              write_mem_i,
  input  logic [31:0]       fifo_in_dout_i,
  input  logic              fifo_in_empty_i,
  output logic              fifo_in_rd_en_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i,
  output logic [31:0]       fifo_out_din_o,
  output logic              fifo_out_wr_en_o,
  input  logic              fifo_out_full_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic [31:0]       word_count_o,
  output logic [31:0]       checksum_o
);

  localparam logic [ADDR_W-1:0] ROM_END   = ADDR_W'(ROM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [31:0]       LAST_WORD = 32'(ROM_BYTES / WORD_BYTES) - 32'd1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       count_q, count_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              rd_pend_q, rd_pend_d;

  logic              skid_push, skid_pop, skid_flush;
  logic              skid_valid;
  logic [31:0]       skid_data;
  logic              addr_in_rom;
  logic [ADDR_W-1:0] addr_inc;
  logic              push;

  // Address bookkeeping; the increment saturates at ROM_END and never wraps
  always_comb begin
    addr_in_rom = (addr_q < ROM_END);
    addr_inc    = (addr_q >= ROM_END - ADDR_STEP) ? ROM_END : addr_q + ADDR_STEP;
  end

  // Next-state and strobe decode; all strobes are dropped while program_en is low
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    count_d          = count_q;
    done_d           = done_q;
    ovf_d            = ovf_q;
    rd_pend_d        = 1'b0;
    fifo_in_rd_en_o  = 1'b0;
    mem_en_o         = 1'b0;
    mem_we_o         = 1'b0;
    mem_din_o        = '0;
    fifo_out_wr_en_o = 1'b0;
    fifo_out_din_o   = '0;
    skid_push        = 1'b0;
    skid_pop         = 1'b0;
    skid_flush       = 1'b0;
    push             = 1'b0;

    if (!program_en_i) begin
      state_d    = ST_IDLE;
      skid_flush = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            addr_d  = '0;
            count_d = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = write_mem_i ? ST_WRITE : ST_READ;
          end
        end

        ST_WRITE: begin
          if (!fifo_in_empty_i && addr_in_rom) begin
            fifo_in_rd_en_o = 1'b1;
            mem_en_o        = 1'b1;
            mem_we_o        = 1'b1;
            mem_din_o       = fifo_in_dout_i;
            addr_d          = addr_inc;
            count_d         = count_q + 32'd1;
          end else if (!fifo_in_empty_i) begin
            // Data with nowhere to go: flag it and discard the rest
            ovf_d   = 1'b1;
            state_d = ST_DRAIN;
          end else if (!write_mem_i) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end

        ST_DRAIN: begin
          if (!fifo_in_empty_i && write_mem_i) begin
            fifo_in_rd_en_o = 1'b1;
          end else if (fifo_in_empty_i && !write_mem_i) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end

        ST_READ: begin
          // The skid entry is always older than any returning word
          if (skid_valid) begin
            if (!fifo_out_full_i) begin
              push           = 1'b1;
              fifo_out_din_o = skid_data;
              skid_pop       = 1'b1;
            end
          end else if (rd_pend_q) begin
            if (!fifo_out_full_i) begin
              push           = 1'b1;
              fifo_out_din_o = mem_dout_i;
            end else begin
              skid_push = 1'b1;
            end
          end
          fifo_out_wr_en_o = push;

          // A read may only be in flight when the skid can absorb its return
          if (!fifo_out_full_i && !skid_valid && addr_in_rom) begin
            mem_en_o  = 1'b1;
            addr_d    = addr_inc;
            rd_pend_d = 1'b1;
          end

          if (push) begin
            count_d = count_q + 32'd1;
            if (count_q == LAST_WORD) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and status registers
  always_ff @(posedge core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  rom_loader_skid u_skid (
    .clk_i   (core_clk_i),
    .rst_i   (reset_i),
    .flush_i (skid_flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (mem_dout_i),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running modulo-2^32 sum of every written word, cleared on an accepted start
  always_ff @(posedge core_clk_i or posedge reset_i) begin
    if (reset_i) begin
      checksum_q <= '0;
    end else if (program_en_i && start_i && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      checksum_q <= '0;
    end else if (mem_we_o) begin
      checksum_q <= checksum_q + mem_din_o;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

  assign mem_addr_o   = addr_q;
  assign busy_o       = is_busy_state(state_q);
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed self-checking bench for rom_loader (16-word ROM)
module tb_rom_loader;

  localparam logic [31:0] ROM_BYTES = 32'h40;
  localparam int          WORDS     = 16;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        program_en = 1'b0;
  logic        start = 1'b0;
  logic        write_mem = 1'b0;
  logic        stall_in = 1'b0;
  logic        fifo_out_full = 1'b0;

  logic [31:0] fifo_mem [0:63];
  int          wp = 0;
  int          rp = 0;
  logic [31:0] rom [0:15];
  logic [31:0] mem_dout = '0;

  logic        fifo_in_empty;
  logic [31:0] fifo_in_dout;
  logic        fifo_in_rd_en, mem_en, mem_we, fifo_out_wr_en;
  logic        busy, done, overflow;
  logic [31:0] mem_addr, mem_din, fifo_out_din, word_count, checksum;

  int          cyc = 0;
  ev_t         wlog[$];
  ev_t         rlog[$];
  ev_t         plog[$];
  int          pops = 0;
  int          we_empty_viol = 0;
  int          push_full_viol = 0;
  int          misalign = 0;
  int          done_cyc = -1;
  logic        done_prev = 1'b0;

  int          checks = 0;
  int          errors = 0;

  assign fifo_in_empty = (rp == wp) || stall_in;
  assign fifo_in_dout  = fifo_mem[rp[5:0]];

  rom_loader #(.ROM_BYTES(ROM_BYTES), .ADDR_W(32)) dut (
    .core_clk_i       (clk),
    .reset_i          (rst),
    .program_en_i     (program_en),
    .start_i          (start),
    .write_mem_i      (write_mem),
    .fifo_in_dout_i   (fifo_in_dout),
    .fifo_in_empty_i  (fifo_in_empty),
    .fifo_in_rd_en_o  (fifo_in_rd_en),
    .mem_en_o         (mem_en),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_din_o        (mem_din),
    .mem_dout_i       (mem_dout),
    .fifo_out_din_o   (fifo_out_din),
    .fifo_out_wr_en_o (fifo_out_wr_en),
    .fifo_out_full_i  (fifo_out_full),
    .busy_o           (busy),
    .done_o           (done),
    .overflow_o       (overflow),
    .word_count_o     (word_count),
    .checksum_o       (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pipe-in read pointer and ROM port A model
  always @(posedge clk) begin
    if (fifo_in_rd_en) rp <= rp + 1;
    if (mem_en && mem_we) rom[mem_addr[5:2]] <= mem_din;
    if (mem_en && !mem_we) mem_dout <= rom[mem_addr[5:2]];
  end

  // Observe strobes mid-cycle
  always @(negedge clk) begin
    if (mem_we) wlog.push_back('{cyc, mem_addr, mem_din});
    if (mem_en && !mem_we) rlog.push_back('{cyc, mem_addr, 32'h0});
    if (fifo_out_wr_en) begin
      plog.push_back('{cyc, 32'h0, fifo_out_din});
      if (fifo_out_full) push_full_viol++;
    end
    if (fifo_in_rd_en) pops++;
    if (mem_we && fifo_in_empty) we_empty_viol++;
    if (mem_en && mem_addr[1:0] != 2'b00) misalign++;
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] v);
    fifo_mem[wp[5:0]] = v;
    wp = wp + 1;
  endtask

  task automatic pulse_start(input logic mode);
    write_mem = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (rp != wp && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (rp != wp) begin
      errors++;
      $display("FAIL %s fifo drain timeout: rp=%0d required wp=%0d", name, rp, wp);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done timeout: done=%b required 1", name, done);
    end
  endtask

  task automatic test_reset();
    int p0;
    repeat (3) tick();
    checks++;
    if ({busy, done, overflow, fifo_in_rd_en, mem_en, mem_we, fifo_out_wr_en} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required 0", {busy, done, overflow, fifo_in_rd_en, mem_en, mem_we, fifo_out_wr_en});
    end
    checks++;
    if (word_count !== 32'h0 || mem_addr !== 32'h0 || checksum !== 32'h0 || mem_din !== 32'h0 || fifo_out_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_buses wc=%h addr=%h cs=%h required 0", word_count, mem_addr, checksum);
    end
    rst = 1'b0;
    tick();
    p0 = pops;
    pulse_start(1'b1);
    tick();
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored busy=%b mem_en=%b required 0 0", busy, mem_en);
    end
  endtask

  task automatic test_write_basic();
    int base, sc, ok;
    program_en = 1'b1;
    tick();
    base = wlog.size();
    for (int i = 0; i < 8; i++) push_word(32'h1000_0000 + i);
    sc = cyc;
    pulse_start(1'b1);
    wait_empty("write_basic");
    write_mem = 1'b0;
    wait_done("write_basic");
    checks++;
    if (wlog.size() - base != 8) begin
      errors++;
      $display("FAIL write_basic_count got=%0d required 8", wlog.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        ok = (wlog[base+i].addr == 32'(i * 4)) && (wlog[base+i].data == 32'h1000_0000 + i) &&
             (wlog[base+i].cyc == sc + 1 + i);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL write_basic_word%0d got addr=%h data=%h cyc=%0d required addr=%h data=%h cyc=%0d",
                   i, wlog[base+i].addr, wlog[base+i].data, wlog[base+i].cyc, i * 4, 32'h1000_0000 + i, sc + 1 + i);
        end
      end
    end
    checks++;
    if (word_count !== 32'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL write_basic_status wc=%0d ovf=%b required 8 0", word_count, overflow);
    end
  endtask

  task automatic test_write_stall();
    int base, sc, v0;
    int exp_off[6] = '{1, 2, 3, 7, 8, 9};
    base = wlog.size();
    v0 = we_empty_viol;
    for (int i = 0; i < 6; i++) push_word(32'h2000_0000 + i);
    sc = cyc;
    pulse_start(1'b1);
    repeat (3) tick();
    stall_in = 1'b1;
    repeat (3) tick();
    stall_in = 1'b0;
    wait_empty("write_stall");
    write_mem = 1'b0;
    wait_done("write_stall");
    checks++;
    if (wlog.size() - base != 6) begin
      errors++;
      $display("FAIL write_stall_count got=%0d required 6", wlog.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wlog[base+i].addr != 32'(i * 4) || wlog[base+i].cyc != sc + exp_off[i]) begin
          errors++;
          $display("FAIL write_stall_word%0d got addr=%h cyc=%0d required addr=%h cyc=%0d",
                   i, wlog[base+i].addr, wlog[base+i].cyc, i * 4, sc + exp_off[i]);
        end
      end
    end
    checks++;
    if (we_empty_viol != v0 || word_count !== 32'd6) begin
      errors++;
      $display("FAIL write_stall_status we_while_empty=%0d wc=%0d required 0 6", we_empty_viol - v0, word_count);
    end
  endtask

  task automatic test_overflow();
    int base, p0;
    base = wlog.size();
    p0 = pops;
    for (int i = 0; i < WORDS + 2; i++) push_word(32'hA500_0000 + i);
    pulse_start(1'b1);
    wait_empty("overflow");
    tick();
    checks++;
    if (overflow !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain ovf=%b done=%b busy=%b required 1 0 1", overflow, done, busy);
    end
    write_mem = 1'b0;
    wait_done("overflow");
    checks++;
    if (wlog.size() - base != WORDS || pops - p0 != WORDS + 2) begin
      errors++;
      $display("FAIL overflow_counts writes=%0d pops=%0d required %0d %0d", wlog.size() - base, pops - p0, WORDS, WORDS + 2);
    end else begin
      checks++;
      if (wlog[base+WORDS-1].addr != 32'h3C || wlog[base+WORDS-1].data != 32'hA500_000F) begin
        errors++;
        $display("FAIL overflow_last got addr=%h data=%h required 0000003c a500000f",
                 wlog[base+WORDS-1].addr, wlog[base+WORDS-1].data);
      end
    end
    checks++;
    if (word_count !== 32'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_status wc=%0d ovf=%b required 16 1", word_count, overflow);
    end
  endtask

  task automatic test_readback();
    int pb, rb, v0, sc, bad;
    pb = plog.size();
    rb = rlog.size();
    v0 = push_full_viol;
    sc = cyc;
    pulse_start(1'b0);
    repeat (3) tick();
    fifo_out_full = 1'b1;
    repeat (4) tick();
    fifo_out_full = 1'b0;
    wait_done("readback");
    tick();
    checks++;
    if (plog.size() - pb != WORDS || rlog.size() - rb != WORDS) begin
      errors++;
      $display("FAIL readback_count pushes=%0d reads=%0d required 16 16", plog.size() - pb, rlog.size() - rb);
    end else begin
      bad = 0;
      for (int i = 0; i < WORDS; i++)
        if (plog[pb+i].data != 32'hA500_0000 + i || rlog[rb+i].addr != 32'(i * 4)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL readback_order got %0d wrong words required 0", bad);
      end
      checks++;
      if (plog[pb].cyc != sc + 2 || plog[pb+1].cyc != sc + 3 || rlog[rb].cyc != sc + 1) begin
        errors++;
        $display("FAIL readback_latency read0=%0d push0=%0d push1=%0d required %0d %0d %0d",
                 rlog[rb].cyc, plog[pb].cyc, plog[pb+1].cyc, sc + 1, sc + 2, sc + 3);
      end
      checks++;
      if (done_cyc != plog[pb+WORDS-1].cyc + 1) begin
        errors++;
        $display("FAIL readback_done_cycle got=%0d required %0d", done_cyc, plog[pb+WORDS-1].cyc + 1);
      end
    end
    checks++;
    if (push_full_viol != v0 || word_count !== 32'd16) begin
      errors++;
      $display("FAIL readback_status push_while_full=%0d wc=%0d required 0 16", push_full_viol - v0, word_count);
    end
  endtask

  task automatic test_abort();
    int pb, rb, sc, got;
    pb = plog.size();
    pulse_start(1'b0);
    repeat (4) tick();
    program_en = 1'b0;
    tick();
    #1;
    got = plog.size() - pb;
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || fifo_out_wr_en !== 1'b0 || got != 3 || word_count !== 32'(got)) begin
      errors++;
      $display("FAIL abort_idle busy=%b mem_en=%b wr_en=%b pushes=%0d wc=%0d required 0 0 0 3 3",
               busy, mem_en, fifo_out_wr_en, got, word_count);
    end
    program_en = 1'b1;
    tick();
    pb = plog.size();
    rb = rlog.size();
    sc = cyc;
    pulse_start(1'b0);
    wait_done("abort_restart");
    tick();
    checks++;
    if (rlog.size() - rb < 1 || plog.size() - pb != WORDS) begin
      errors++;
      $display("FAIL abort_restart_count reads=%0d pushes=%0d required >0 16", rlog.size() - rb, plog.size() - pb);
    end else begin
      checks++;
      if (rlog[rb].addr != 32'h0 || rlog[rb].cyc != sc + 1 || plog[pb].data != 32'hA500_0000) begin
        errors++;
        $display("FAIL abort_restart_first addr=%h cyc=%0d data=%h required 0 %0d a5000000",
                 rlog[rb].addr, rlog[rb].cyc, plog[pb].data, sc + 1);
      end
    end
  endtask

  task automatic test_checksum();
    logic [31:0] exp_cs;
`ifdef ROM_LOADER_CHECKSUM_EN
    exp_cs = 32'h0000_0001;
`else
    exp_cs = 32'h0000_0000;
`endif
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0002);
    pulse_start(1'b1);
    wait_empty("checksum");
    write_mem = 1'b0;
    wait_done("checksum");
    checks++;
    if (checksum !== exp_cs || word_count !== 32'd2) begin
      errors++;
      $display("FAIL checksum got cs=%h wc=%0d required cs=%h wc=2", checksum, word_count, exp_cs);
    end
    checks++;
    if (misalign != 0) begin
      errors++;
      $display("FAIL addr_align got %0d misaligned accesses required 0", misalign);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) fifo_mem[i] = '0;
    test_reset();
    test_write_basic();
    test_write_stall();
    test_overflow();
    test_readback();
    test_abort();
    test_checksum();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Programming-path controller between the host pipe FIFOs and port A of the instruction ROM, active while the core is held in program reset. On a start trigger it does one of two things. In write mode it drains words from the pipe-in FIFO into consecutive ROM addresses. In readback mode it streams the whole ROM into the pipe-out FIFO. It replaces ad-hoc address counting with a defined state machine that handles backpressure and overflow and reports completion status to a wire-out.

## Interface
- ROM_BYTES, 32'h8000, ROM size in bytes; must be a multiple of 4.
- ADDR_W, 32, width of the byte address bus.
- core_clk  in  1  core clock; also clocks the FIFO read side of pipe-in and the write side of pipe-out.
- reset  in  1  asynchronous, active-high reset.
- program_en  in  1  level input; high while the core is held in program reset.
- start  in  1  single-cycle trigger that begins an operation.
- write_mem  in  1  mode select, sampled on start: 1 = write, 0 = readback.
- fifo_in_dout  in  32  pipe-in data from a first-word-fall-through FIFO.
- fifo_in_empty  in  1  pipe-in empty flag.
- fifo_in_rd_en  out  1  pipe-in pop.
- mem_en  out  1  ROM port enable.
- mem_we  out  1  ROM port write enable.
- mem_addr  out  ADDR_W  byte address; always word-aligned.
- mem_din  out  32  ROM write data.
- mem_dout  in  32  ROM read data; valid 1 cycle after mem_en with mem_we low.
- fifo_out_din  out  32  pipe-out data.
- fifo_out_wr_en  out  1  pipe-out push.
- fifo_out_full  in  1  pipe-out full flag.
- busy  out  1  high in WRITE, READ or DRAIN.
- done  out  1  sticky; set on entry to DONE.
- overflow  out  1  sticky; set when write data arrives at or past ROM_BYTES.
- word_count  out  32  number of words written or pushed in the current operation.
- checksum  out  32  running 32-bit sum of written words; present only with ROM_LOADER_CHECKSUM_EN.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - On start with program_en high, clear word_count, checksum, done, overflow and the address counter.
  - Then go to WRITE if write_mem=1, otherwise READ.
  - start is ignored when program_en is low.
- WRITE:
  - Each cycle fifo_in_empty=0 and address < ROM_BYTES: assert fifo_in_rd_en, mem_en and mem_we.
  - In the same cycle drive mem_din = fifo_in_dout, then advance address by 4 and word_count by 1.
  - write_mem falling with the FIFO empty → DONE.
  - Address reaching ROM_BYTES with fifo_in_empty=0 → set overflow, go to DRAIN.
- DRAIN: pop and discard while fifo_in_empty=0 and write_mem=1. When write_mem=0 and the FIFO is empty → DONE.
- READ:
  - Issue a read (mem_en=1, mem_we=0) when fifo_out_full=0, the skid register is empty and address < ROM_BYTES.
  - Returned data is pushed directly when fifo_out_full=0 on its return cycle; otherwise it is captured in the skid register.
  - The skid register pushes first once full drops, and no new read is issued while it holds data.
  - After ROM_BYTES/4 words have been pushed → DONE.
- DONE: hold done=1 and all strobes low. A new start returns to the IDLE start behaviour.
- program_en low in any state: return to IDLE in the next cycle and drop strobes. done, overflow and word_count hold their values; the skid register is cleared.
- Arithmetic:
  - The address counter is ADDR_W bits and never wraps; it saturates at ROM_BYTES.
  - Checksum is a modulo-2^32 sum.

## Timing
- Reset: every output is 0, state is IDLE, address is 0.
- start to first mem_en: 1 cycle (the state register updates, then strobes are combinational from state and flags).
- Write throughput is 1 word per cycle while the FIFO is non-empty.
- Readback throughput is 1 word per cycle with no backpressure. At most one word sits in the skid register, so no push is ever issued while fifo_out_full=1.
- done rises the cycle after the last push or write.

## Configuration
- ROM_LOADER_CHECKSUM_EN defined: checksum accumulates mem_din on every write strobe and is cleared on start.
- Not defined: checksum is tied to 0 and the adder is not built.

## Structure
- Package rom_loader_pkg holds the state enum, WORD_BYTES=4 and the default ROM_BYTES.
- Sub-module rom_loader_skid is a one-entry skid register (valid/data, push/pop) used on the readback return path.

## Test plan
- Write 8 words 0x1000_0000..0x1000_0007 with no stalls:
  - Expect 8 consecutive cycles of mem_we at addresses 0x0..0x1C.
  - Expect word_count=8 and done=1.
- Write with pipe-in empty for 3 cycles mid-stream: no mem_we while empty, addresses stay contiguous, final word_count matches the number of words pushed.
- Readback with ROM_BYTES=32'h40 and fifo_out_full pulsed high for 4 cycles:
  - Expect exactly 16 pushes in address order, with no push while full.
  - The skid register absorbs the one in-flight word.
- Write ROM_BYTES/4+2 words: overflow=1, the last 2 words are popped but not written, done after write_mem falls.
- Deassert program_en mid-readback: the next cycle is IDLE with strobes low, and a new start restarts at address 0.
- With ROM_LOADER_CHECKSUM_EN defined, write 0xFFFF_FFFF then 0x0000_0002: checksum=0x0000_0001.
